// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared types for the Vermicel bus arbiter: bus word/strobe types, master
// identifier, arbiter state encoding and the default timed-out read value.
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  wstrobe_t;
    typedef logic [0:0]  master_id_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_M0,
        BUSY_M1
    } arbiter_state_t;

    localparam word_t BUS_TIMEOUT_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // BUSY state that serves the given master.
    function automatic arbiter_state_t busy_state(input master_id_t id);
        return (id == 1'b1) ? BUSY_M1 : BUSY_M0;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// ---------------------------------------------------------------------------
// bus_timeout_counter
// 16-bit wait counter for the arbiter's forced-completion feature.
//   clk     : system clock, rising edge
//   reset   : synchronous, active-high reset (count <= 0)
//   clear   : synchronous clear, overrides enable
//   enable  : increment by one this cycle
//   limit   : terminal count
//   expired : high while count == limit
// ---------------------------------------------------------------------------
module bus_timeout_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] limit,
    output logic        expired
);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign expired = (r_count == limit);

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Two-master, one-slave round-robin arbiter for the Vermicel memory bus.
// A grant is taken in a registered IDLE cycle and held until the slave
// completes the handshake; every completion returns through IDLE.
//
// Optional feature macro: BUS_ARBITER_TIMEOUT_EN
//   defined   : a granted transaction waiting TIMEOUT_CYCLES cycles for
//               s_ready is force-completed with TIMEOUT_RDATA and a timeout
//               pulse.
//   undefined : no counter, timeout tied to 0, waits are unbounded.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   m0_* / m1_*                      master request channels (valid, address,
//                                    wstrobe, wdata in; ready, rdata out)
//   s_*                              slave request channel
//   timeout                          one-cycle forced-completion pulse
// ---------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int    TIMEOUT_CYCLES = 255,
    parameter word_t TIMEOUT_RDATA  = BUS_TIMEOUT_RDATA_DEFAULT
) (
    input  logic     clk,
    input  logic     reset,

    input  logic     m0_valid,
    output logic     m0_ready,
    input  word_t    m0_address,
    input  wstrobe_t m0_wstrobe,
    input  word_t    m0_wdata,
    output word_t    m0_rdata,

    input  logic     m1_valid,
    output logic     m1_ready,
    input  word_t    m1_address,
    input  wstrobe_t m1_wstrobe,
    input  word_t    m1_wdata,
    output word_t    m1_rdata,

    output logic     s_valid,
    input  logic     s_ready,
    output word_t    s_address,
    output wstrobe_t s_wstrobe,
    output word_t    s_wdata,
    input  word_t    s_rdata,

    output logic     timeout
);

    arbiter_state_t r_state;
    arbiter_state_t w_state_next;
    master_id_t     r_last_grant;
    master_id_t     w_last_grant_next;

    logic       w_busy;
    master_id_t w_cur;
    logic       w_granted_valid;
    logic       w_timeout_hit;

    assign w_busy          = (r_state != IDLE);
    assign w_cur           = (r_state == BUSY_M1);
    assign w_granted_valid = w_cur ? m1_valid : m0_valid;

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic w_expired;

    // Count is held at zero in IDLE so it starts from 0 on BUSY entry.
    bus_timeout_counter u_timeout_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (~w_busy),
        .enable  (w_busy & ~s_ready),
        .limit   (16'(TIMEOUT_CYCLES)),
        .expired (w_expired)
    );

    // A real completion in the same cycle takes precedence over the timeout.
    assign w_timeout_hit = w_busy & w_granted_valid & w_expired & ~s_ready;
`else
    assign w_timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        case (r_state)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    w_state_next = busy_state(~r_last_grant);
                end else if (m0_valid) begin
                    w_state_next = BUSY_M0;
                end else if (m1_valid) begin
                    w_state_next = BUSY_M1;
                end
            end
            BUSY_M0, BUSY_M1: begin
                if (!w_granted_valid) begin
                    // Master withdrew: abandon without crediting its turn.
                    w_state_next = IDLE;
                end else if (s_ready || w_timeout_hit) begin
                    w_state_next      = IDLE;
                    w_last_grant_next = w_cur;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        s_valid   = 1'b0;
        s_address = m0_address;
        s_wstrobe = m0_wstrobe;
        s_wdata   = m0_wdata;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        timeout   = w_timeout_hit;
        if (w_busy) begin
            s_address = w_cur ? m1_address : m0_address;
            s_wstrobe = w_cur ? m1_wstrobe : m0_wstrobe;
            s_wdata   = w_cur ? m1_wdata   : m0_wdata;
            s_valid   = w_granted_valid & ~w_timeout_hit;
            if (w_cur) begin
                m1_ready = (s_ready & m1_valid) | w_timeout_hit;
            end else begin
                m0_ready = (s_ready & m0_valid) | w_timeout_hit;
            end
        end
    end

    // Read data is broadcast; each master samples it only with its own ready.
    assign m0_rdata = w_timeout_hit ? TIMEOUT_RDATA : s_rdata;
    assign m1_rdata = m0_rdata;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the Vermicel memory bus (valid/ready handshake, word_t address/wdata/rdata, wstrobe_t strobes).
- Shares a single memory or IO slave between the Vermicel core (m0) and a second requester such as a DMA or debug port (m1).
- Round-robin, transaction-granular: a grant is held until the slave completes the handshake.
- Sits between the masters and the address decoder/interconnect.

Parameters:
- TIMEOUT_CYCLES, 255, cycles a granted transaction may wait for s_ready before forced completion (used only with BUS_ARBITER_TIMEOUT_EN); range 1..65535.
- TIMEOUT_RDATA, 32'hDEAD_BEEF, rdata returned to the master on a timed-out transaction.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- m0_valid  in  1  master 0 request
- m0_ready  out  1  master 0 completion
- m0_address  in  32  word_t byte address
- m0_wstrobe  in  4  wstrobe_t; 0 = read
- m0_wdata  in  32  word_t write data
- m0_rdata  out  32  word_t read data
- m1_valid, m1_ready, m1_address, m1_wstrobe, m1_wdata, m1_rdata: same as m0 for master 1
- s_valid  out  1  request to slave
- s_ready  in  1  slave completion
- s_address  out  32  forwarded address
- s_wstrobe  out  4  forwarded strobes
- s_wdata  out  32  forwarded write data
- s_rdata  in  32  slave read data
- timeout  out  1  one-cycle pulse when a transaction is force-completed; constant 0 without the macro

Behaviour:
- State machine states: IDLE, BUSY_M0, BUSY_M1. Register last_grant (1 bit) holds the id of the last master that completed a transaction.
- Reset (sync, reset=1 at a rising edge):
  - state <= IDLE, last_grant <= 1, so m0 wins the first tie.
  - Timeout counter <= 0.
  - Outputs while in IDLE: s_valid=0, m0_ready=m1_ready=0, timeout=0.
- Reset has priority over every other event, including mid-transaction: the transaction is abandoned, no ready is issued, and the slave sees s_valid drop.
- IDLE:
  - s_valid=0; s_address/s_wstrobe/s_wdata = m0 payload (don't-care).
  - If exactly one mX_valid=1, the next state is BUSY_MX.
  - If both are valid, grant the master != last_grant.
  - If neither is valid, stay in IDLE.
  - The arbitration cycle is registered; there is no combinational path from mX_valid to s_valid.
- BUSY_MX:
  - s_valid=mX_valid and s_address/s_wstrobe/s_wdata = mX payload, combinationally muxed.
  - mX_ready = s_ready; the other master's ready = 0.
  - On s_valid & s_ready: last_grant <= X, next state IDLE.
  - If mX_valid drops before completion (protocol violation): next state IDLE, last_grant unchanged, no ready is issued.
- m0_rdata and m1_rdata both carry s_rdata (broadcast). A master samples rdata only when its own ready is high.
- Latency: a request issued at cycle t appears on s_valid at t+1. With a 0-wait slave, mX_ready is high at t+1.
- Throughput: at most one transaction per 2 cycles, because every completion passes through IDLE.
- Fairness: under continuous requests from both masters, grants alternate m0, m1, m0, ...
- Masters must hold valid and payload stable until ready (Vermicel bus rule). The arbiter does not register the payload.

Optional Feature:
- BUS_ARBITER_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to BUSY_* and increments each BUSY cycle with s_ready=0.
  - When the counter == TIMEOUT_CYCLES and s_ready=0 in that cycle: mX_ready=1, mX_rdata=TIMEOUT_RDATA, s_valid=0, timeout=1 for that cycle; last_grant <= X; next state IDLE.
  - If s_ready=1 in that same cycle, normal completion wins and timeout=0.
- Undefined: no counter is instantiated, timeout is tied to 0, and a BUSY state can wait indefinitely.

Decomposition:
- Vermitypes_pkg gains:
  - master_id_t: 1-bit unsigned.
  - arbiter_state_t: enum IDLE, BUSY_M0, BUSY_M1.
  - localparam word_t BUS_TIMEOUT_RDATA_DEFAULT = 32'hDEAD_BEEF.
- One sub-module is natural: bus_timeout_counter (clk, reset, clear, enable, limit → expired), instantiated only under BUS_ARBITER_TIMEOUT_EN.

Test Plan:
- Reset, then m0 read of address 0x100; slave returns 0x12345678 with 0 wait → s_valid at cycle 1, m0_ready=1 with m0_rdata=0x12345678 at cycle 1, m1_ready=0 throughout.
- Both masters valid at the same cycle after reset → m0 granted first; m1 is granted in the cycle after m0 completes. Continuous requests over 6 transactions → order m0, m1, m0, m1, m0, m1.
- m1 write to 0x200, wdata 0xCAFEF00D, wstrobe 4'b0011, slave waits 3 cycles → s_* payload matches exactly on all 4 BUSY cycles, m1_ready is high only on the 4th, and m0 is blocked throughout.
- reset asserted on the 2nd wait cycle of an m0 transaction → next cycle state IDLE, s_valid=0, m0_ready never asserted; the next tie after reset goes to m0.
- Granted m1 deasserts valid mid-wait → arbiter returns to IDLE, last_grant is still 0, and a following tie is granted to m1.
- Macro defined, TIMEOUT_CYCLES=4, slave never asserts s_ready → on BUSY cycle 5 (counter==4), m0_ready=1, m0_rdata=0xDEADBEEF, timeout=1, s_valid=0; a variant with s_ready=1 on that same cycle gives normal completion with timeout=0.
